// File: rtl/lz4_pkg.sv
// Shared LZ4 datapath constants used by the match finder, the stream FIFO and the encoder.
// The defaults size the FIFO as a 4K-entry buffer of 32-bit words.
package lz4_pkg;

   localparam int LZ4_DATA_W       = 32;
   localparam int LZ4_ADDR_W       = 12;
   localparam int LZ4_AFULL_THRESH = 4064;

endpackage

// File: rtl/lz4_sdp_ram.sv
// Simple dual-port RAM with one write port and one registered read port.
// Only the read register is reset. The storage array has no reset, so it can infer block RAM.
module lz4_sdp_ram #(
   parameter int W  = 33,
   parameter int AW = 12
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);

   logic [W-1:0] r_mem [2**AW];
   logic [W-1:0] r_rdata;

   always_ff @(posedge clk) begin
      if (we) r_mem[waddr] <= wdata;
   end

   // The read register holds its value between reads, so odata stays stable.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)     r_rdata <= '0;
      else if (re) r_rdata <= r_mem[raddr];
   end

   assign rdata = r_rdata;

endmodule

// File: rtl/lz4_stream_fifo.sv
// Stream FIFO between the LZ4 match finder and the sequence encoder. Each word carries an end-of-file tag.
// This level holds the pointers, the occupancy count, the sticky error flags and the file-end tracking.
module lz4_stream_fifo
   import lz4_pkg::*;
#(
   parameter int DATA_W       = LZ4_DATA_W,
   parameter int ADDR_W       = LZ4_ADDR_W,
   parameter int AFULL_THRESH = LZ4_AFULL_THRESH
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_compress,
   input  logic              flush,
   input  logic              data_terminal,
   input  logic              wr_req,
   input  logic              wr_last,
   input  logic [DATA_W-1:0] idata,
   input  logic              rd_req,
   output logic [DATA_W-1:0] odata,
   output logic              odata_last,
   output logic              odata_valid,
   output logic [ADDR_W:0]   count,
   output logic              empty,
   output logic              full,
   output logic              almost_full,
   output logic              overflow,
   output logic              underflow,
   output logic              file_end
);

   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(1 << ADDR_W);
   localparam logic [ADDR_W:0] AFULL_C = (ADDR_W+1)'(AFULL_THRESH);

   logic [ADDR_W-1:0] r_wr_ptr;
   logic [ADDR_W-1:0] r_rd_ptr;
   logic [ADDR_W:0]   r_count;
   logic              r_odata_valid;
   logic              r_overflow;
   logic              r_underflow;
   logic              r_term_seen;
   logic              r_file_end;

   logic              w_full;
   logic              w_empty;
   logic              w_wr_acc;
   logic              w_rd_acc;
   logic [DATA_W:0]   w_rdata;

   assign w_full   = (r_count == DEPTH_C);
   assign w_empty  = (r_count == '0);
   assign w_wr_acc = wr_req & ~w_full  & ~flush;
   assign w_rd_acc = rd_req & ~w_empty & ~flush;

   lz4_sdp_ram #(
      .W  (DATA_W + 1),
      .AW (ADDR_W)
   ) u_ram (
      .clk   (clk),
      .rst   (rst),
      .we    (w_wr_acc),
      .waddr (r_wr_ptr),
      .wdata ({wr_last, idata}),
      .re    (w_rd_acc),
      .raddr (r_rd_ptr),
      .rdata (w_rdata)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_wr_acc, w_rd_acc})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // A flush leaves the sticky flags, the term state and any read already in flight untouched.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_odata_valid <= 1'b0;
         r_overflow    <= 1'b0;
         r_underflow   <= 1'b0;
         r_term_seen   <= 1'b0;
         r_file_end    <= 1'b0;
      end else begin
         r_odata_valid <= w_rd_acc;
         if (start_compress) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_term_seen <= 1'b0;
            r_file_end  <= 1'b0;
         end else begin
            if (wr_req & w_full)  r_overflow  <= 1'b1;
            if (rd_req & w_empty) r_underflow <= 1'b1;
            if (data_terminal | (w_wr_acc & wr_last)) r_term_seen <= 1'b1;
            if ((r_term_seen & w_empty & ~r_odata_valid) | (r_odata_valid & w_rdata[DATA_W]))
               r_file_end <= 1'b1;
         end
      end
   end

   assign odata       = w_rdata[DATA_W-1:0];
   assign odata_last  = w_rdata[DATA_W];
   assign odata_valid = r_odata_valid;
   assign count       = r_count;
   assign empty       = w_empty;
   assign full        = w_full;
   assign almost_full = (r_count >= AFULL_C);
   assign overflow    = r_overflow;
   assign underflow   = r_underflow;
   assign file_end    = r_file_end;

endmodule

// File: tb/tb_lz4_stream_fifo.sv
// Testbench for lz4_stream_fifo with a 16-entry FIFO and an almost-full threshold of 12.
// A queue holds the expected read data. A reference model tracks count, flags and file_end every cycle.
module tb_lz4_stream_fifo;

   localparam int DW    = 32;
   localparam int AW    = 4;
   localparam int DEPTH = 16;
   localparam int AFT   = 12;

   logic          clk = 1'b0;
   logic          rst;
   logic          start_compress, flush, data_terminal;
   logic          wr_req, wr_last, rd_req;
   logic [DW-1:0] idata;
   logic [DW-1:0] odata;
   logic          odata_last, odata_valid;
   logic [AW:0]   count;
   logic          empty, full, almost_full, overflow, underflow, file_end;

   always #5 clk = ~clk;

   lz4_stream_fifo #(.DATA_W(DW), .ADDR_W(AW), .AFULL_THRESH(AFT)) dut (
      .clk            (clk),
      .rst            (rst),
      .start_compress (start_compress),
      .flush          (flush),
      .data_terminal  (data_terminal),
      .wr_req         (wr_req),
      .wr_last        (wr_last),
      .idata          (idata),
      .rd_req         (rd_req),
      .odata          (odata),
      .odata_last     (odata_last),
      .odata_valid    (odata_valid),
      .count          (count),
      .empty          (empty),
      .full           (full),
      .almost_full    (almost_full),
      .overflow       (overflow),
      .underflow      (underflow),
      .file_end       (file_end)
   );

   int          n_checks = 0;
   int          n_errors = 0;
   logic [32:0] q[$];
   int          m_count;
   logic        m_ovf, m_unf, m_valid, m_vlast, m_fe, m_term;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_count = 0;
      m_ovf   = 1'b0;
      m_unf   = 1'b0;
      m_valid = 1'b0;
      m_vlast = 1'b0;
      m_fe    = 1'b0;
      m_term  = 1'b0;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_count"}, 64'(count), 64'd0);
      check({tag, "_empty"}, 64'(empty), 64'd1);
      check({tag, "_full"}, 64'(full), 64'd0);
      check({tag, "_afull"}, 64'(almost_full), 64'd0);
      check({tag, "_valid"}, 64'(odata_valid), 64'd0);
      check({tag, "_odata"}, 64'(odata), 64'd0);
      check({tag, "_olast"}, 64'(odata_last), 64'd0);
      check({tag, "_ovf"}, 64'(overflow), 64'd0);
      check({tag, "_unf"}, 64'(underflow), 64'd0);
      check({tag, "_fend"}, 64'(file_end), 64'd0);
   endtask

   // One clock cycle: drive the inputs, step the reference model, then compare after the edge.
   task automatic cyc(input logic w, input logic l, input logic [DW-1:0] d, input logic r,
                      input logic fl = 1'b0, input logic sc = 1'b0, input logic term = 1'b0);
      logic        wa, ra, fe_n, term_n;
      logic [32:0] exp;
      exp    = '0;
      wa     = w && (m_count < DEPTH) && !fl;
      ra     = r && (m_count > 0) && !fl;
      fe_n   = sc ? 1'b0 : (m_fe | (m_term && m_count == 0 && !m_valid) | (m_valid && m_vlast));
      term_n = sc ? 1'b0 : (m_term | term | (wa & l));
      if (sc) begin
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end else begin
         if (w && m_count == DEPTH) m_ovf = 1'b1;
         if (r && m_count == 0)     m_unf = 1'b1;
      end
      wr_req = w; wr_last = l; idata = d; rd_req = r;
      flush = fl; start_compress = sc; data_terminal = term;
      @(posedge clk);
      #1;
      wr_req = 0; wr_last = 0; idata = '0; rd_req = 0;
      flush = 0; start_compress = 0; data_terminal = 0;
      if (ra) exp = q.pop_front();
      if (wa) q.push_back({l, d});
      if (fl) begin
         q.delete();
         m_count = 0;
      end else begin
         m_count = m_count + int'(wa) - int'(ra);
      end
      m_fe    = fe_n;
      m_term  = term_n;
      m_valid = ra;
      if (ra) m_vlast = exp[32];
      check("count", 64'(count), 64'(m_count));
      check("empty", 64'(empty), 64'(m_count == 0));
      check("full", 64'(full), 64'(m_count == DEPTH));
      check("almost_full", 64'(almost_full), 64'(m_count >= AFT));
      check("overflow", 64'(overflow), 64'(m_ovf));
      check("underflow", 64'(underflow), 64'(m_unf));
      check("odata_valid", 64'(odata_valid), 64'(ra));
      check("file_end", 64'(file_end), 64'(m_fe));
      if (ra) begin
         check("odata", 64'(odata), 64'(exp[31:0]));
         check("odata_last", 64'(odata_last), 64'(exp[32]));
      end
   endtask

   task automatic wr(input logic [DW-1:0] d, input logic l = 1'b0);
      cyc(1'b1, l, d, 1'b0);
   endtask

   task automatic rd();
      cyc(1'b0, 1'b0, '0, 1'b1);
   endtask

   task automatic idle();
      cyc(1'b0, 1'b0, '0, 1'b0);
   endtask

   initial begin
      rst = 1'b1;
      start_compress = 0; flush = 0; data_terminal = 0;
      wr_req = 0; wr_last = 0; idata = '0; rd_req = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_reset_state("reset");
      rst = 1'b0;

      // single word round trip
      wr(32'hA5A5_0001);
      rd();
      idle();

      // fill to full, reject the 17th write, then drain in order
      for (int i = 0; i < DEPTH; i++) wr(32'h1000_0000 + i);
      wr(32'hDEAD_BEEF);
      for (int i = 0; i < DEPTH; i++) rd();
      idle();

      // refill, then read and write together starting from full
      for (int i = 0; i < DEPTH; i++) wr(32'h2000_0000 + i);
      for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0, 32'h3000_0000 + i, 1'b1);
      while (m_count > 0) rd();
      idle();
      cyc(1'b1, 1'b0, 32'h4444_0001, 1'b1);
      rd();
      idle();

      // a tagged end of file, then start_compress clears file_end and the flags
      cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
      wr(32'h5000_0001);
      wr(32'h5000_0002);
      wr(32'h5000_0003, 1'b1);
      rd(); rd(); rd();
      idle(); idle();
      cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
      idle();

      // an untagged data_terminal: file_end waits until the FIFO has drained
      for (int i = 0; i < 5; i++) wr(32'h6000_0000 + i);
      cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) rd();
      idle(); idle(); idle();
      cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);

      // flush in the middle of a stream; the read before the flush still returns its data
      for (int i = 0; i < 6; i++) wr(32'h7000_0000 + i);
      rd();
      cyc(1'b1, 1'b0, 32'h7777_7777, 1'b1, 1'b1);
      idle();

      // pointers wrap past the depth several times over 40 words
      for (int i = 0; i < 40; i++) cyc(1'b1, 1'b0, $urandom, m_count >= 5);
      while (m_count > 0) rd();
      idle();

      // an asynchronous reset in the middle of a transfer takes effect before the next clock edge
      wr(32'h9000_0001);
      cyc(1'b1, 1'b0, 32'h9000_0002, 1'b1);
      #3 rst = 1'b1;
      #1;
      check_reset_state("async_rst");
      model_reset();
      @(posedge clk);
      #1 rst = 1'b0;
      wr(32'hAB00_0001);
      rd();
      idle();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
